// File: rtl/rhd_cmd_if.sv
// rhd_cmd_if: host register-write and SPI command handshake bundle
//   host_wr_valid/ready, host_wr_addr[5:0], host_wr_data[7:0] : register-write push into the scheduler
//   cmd_valid/ready, cmd_data[15:0], cmd_slot[7:0], cmd_frame_start : command stream to the SPI engine
//   master = scheduler side, slave = host / SPI engine side
interface rhd_cmd_if;
  logic host_wr_valid;
  logic host_wr_ready;
  logic [5:0] host_wr_addr;
  logic [7:0] host_wr_data;
  logic cmd_valid;
  logic cmd_ready;
  logic [15:0] cmd_data;
  logic [7:0] cmd_slot;
  logic cmd_frame_start;
  modport master(
    input host_wr_valid, host_wr_addr, host_wr_data, cmd_ready,
    output host_wr_ready, cmd_valid, cmd_data, cmd_slot, cmd_frame_start
  );
  modport slave(
    output host_wr_valid, host_wr_addr, host_wr_data, cmd_ready,
    input host_wr_ready, cmd_valid, cmd_data, cmd_slot, cmd_frame_start
  );
endinterface

// File: rtl/rhd_cmd_scheduler.sv
// rhd_cmd_scheduler: RHD command sequencer for calibration, register writes and frame streaming
//   clk, rst (sync, active-high); start_record / stop_record / start_calib : one-cycle request pulses
//   bus : rhd_cmd_if.master (register-write FIFO push, command handshake to the SPI engine)
//   busy : not IDLE; frame_count : frames started since reset
module rhd_cmd_scheduler #(
  parameter int NUM_CH = 64,
  parameter int AUX_SLOTS = 3,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start_record,
  input  logic stop_record,
  input  logic start_calib,
  rhd_cmd_if.master bus,
  output logic busy,
  output logic [15:0] frame_count
);
  localparam int AW = WFIFO_DEPTH > 1 ? $clog2(WFIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [7:0] LAST = 8'(NUM_CH + AUX_SLOTS - 1);
  localparam logic [15:0] DUMMY = 16'hE800;
  localparam logic [15:0] CALIBRATE = 16'h5500;
  typedef enum logic [2:0] {IDLE, WRITE, CALIB, RECORD, STOPPING} state_t;
  state_t state;
  logic [13:0] mem [WFIFO_DEPTH];
  logic [AW-1:0] rptr, wptr, rptr_inc, wptr_inc;
  logic [CW-1:0] count;
  logic [7:0] slot, ns;
  logic [3:0] calib_cnt;
  logic [13:0] head_nx;
  logic [15:0] slot_cmd;
  logic aux_wr, xfer, push, pop, avail;
  assign xfer = bus.cmd_valid & bus.cmd_ready;
  assign push = bus.host_wr_valid & bus.host_wr_ready;
  assign pop = xfer & (state == WRITE | aux_wr);
  assign bus.host_wr_ready = count != CW'(WFIFO_DEPTH);
  assign rptr_inc = rptr == AW'(WFIFO_DEPTH - 1) ? '0 : rptr + AW'(1);
  assign wptr_inc = wptr == AW'(WFIFO_DEPTH - 1) ? '0 : wptr + AW'(1);
  // Next aux slot sees the FIFO as it stands after this cycle's pop; a same-cycle push is not yet visible.
  assign head_nx = mem[pop ? rptr_inc : rptr];
  assign avail = count != CW'(pop);
  assign ns = slot == LAST ? '0 : slot + 8'd1;
  assign slot_cmd = ns < 8'(NUM_CH) ? {2'b00, ns[5:0], 8'h00} : avail ? {2'b10, head_nx} : DUMMY;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {bus.host_wr_addr, bus.host_wr_data};
        wptr <= wptr_inc;
      end
      if (pop) rptr <= rptr_inc;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      slot <= '0;
      calib_cnt <= '0;
      aux_wr <= 1'b0;
      frame_count <= '0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_data <= '0;
      bus.cmd_slot <= '0;
      bus.cmd_frame_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_calib) begin
            state <= CALIB;
            calib_cnt <= '0;
            bus.cmd_valid <= 1'b1;
            bus.cmd_data <= CALIBRATE;
          end else if (start_record) begin
            state <= RECORD;
            slot <= '0;
            aux_wr <= 1'b0;
            bus.cmd_valid <= 1'b1;
            bus.cmd_data <= 16'h0000;
            bus.cmd_slot <= '0;
            bus.cmd_frame_start <= 1'b1;
          end else if (count != '0) begin
            state <= WRITE;
            bus.cmd_valid <= 1'b1;
            bus.cmd_data <= {2'b10, mem[rptr]};
          end
        end
        WRITE: begin
          if (xfer) begin
            state <= IDLE;
            bus.cmd_valid <= 1'b0;
            bus.cmd_data <= '0;
          end
        end
        CALIB: begin
          if (xfer && calib_cnt == 4'd9) begin
            state <= IDLE;
            bus.cmd_valid <= 1'b0;
            bus.cmd_data <= '0;
          end else if (xfer) begin
            calib_cnt <= calib_cnt + 4'd1;
            bus.cmd_data <= DUMMY;
          end
        end
        default: begin
          if (state == RECORD && stop_record) state <= STOPPING;
          if (xfer && slot == '0) frame_count <= frame_count + 16'd1;
          // A stop landing on the last-slot transfer ends the stream here instead of opening a new frame.
          if (xfer && slot == LAST && (state == STOPPING || stop_record)) begin
            state <= IDLE;
            slot <= '0;
            aux_wr <= 1'b0;
            bus.cmd_valid <= 1'b0;
            bus.cmd_data <= '0;
            bus.cmd_slot <= '0;
            bus.cmd_frame_start <= 1'b0;
          end else if (xfer) begin
            slot <= ns;
            aux_wr <= ns >= 8'(NUM_CH) && avail;
            bus.cmd_data <= slot_cmd;
            bus.cmd_slot <= ns;
            bus.cmd_frame_start <= ns == '0;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/rhd_cmd_scheduler.md
RHD_CMD_SCHEDULER -- requirements
Module: rhd_cmd_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 64, the number of CONVERT slots per frame (1..64).
REQ-002 SHALL have parameter AUX_SLOTS, default 3, the number of auxiliary slots per frame (1..4).
REQ-003 SHALL have parameter WFIFO_DEPTH, default 4, the number of entries in the register-write FIFO (power of 2).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start_record  in  1  one-cycle pulse that requests continuous frame streaming.
REQ-007 stop_record  in  1  one-cycle pulse that requests the end of streaming at the frame boundary.
REQ-008 start_calib  in  1  one-cycle pulse that requests the ADC calibration sequence.
REQ-009 host_wr_valid / host_wr_ready  in / out  1 / 1  register-write handshake.
REQ-010 host_wr_addr  in  6  register address; host_wr_data  in  8  register value.
REQ-011 cmd_valid / cmd_ready  out / in  1 / 1  command handshake to the SPI engine.
REQ-012 cmd_data  out  16  RHD command word.
REQ-013 cmd_slot  out  8  slot index of the current command within the frame (0 outside RECORD).
REQ-014 cmd_frame_start  out  1  high while slot 0 of a RECORD frame is presented.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 frame_count  out  16  count of frames started since reset.

Function
REQ-017 Encodings SHALL be: CONVERT(c) = {2'b00, c[5:0], 8'h00}; WRITE(r,d) = {2'b10, r, d}; DUMMY = READ(40) = 16'hE800; CALIBRATE = 16'h5500.
REQ-018 A command SHALL transfer on a cycle where cmd_valid and cmd_ready are both high; cmd_data, cmd_slot and cmd_frame_start SHALL hold stable while cmd_valid is high and cmd_ready is low.
REQ-019 States SHALL be IDLE, WRITE, CALIB, RECORD and STOPPING.
REQ-020 In IDLE, one cycle is evaluated with this priority: start_calib -> CALIB; else start_record -> RECORD; else FIFO non-empty -> WRITE. cmd_valid SHALL assert on the next cycle.
REQ-021 start_calib and start_record pulses that arrive in any state other than IDLE SHALL be dropped; stop_record outside RECORD SHALL be dropped.
REQ-022 WRITE SHALL pop one FIFO entry, present WRITE(addr,data), and return to IDLE on the cycle of transfer.
REQ-023 CALIB SHALL present CALIBRATE followed by 9 DUMMY commands (10 transfers total), then return to IDLE.
REQ-024 A RECORD frame SHALL be NUM_CH+AUX_SLOTS slots: slots 0..NUM_CH-1 present CONVERT(slot).
REQ-025 In each aux slot, if the FIFO is non-empty the scheduler SHALL present WRITE from the FIFO head and pop on transfer; otherwise it SHALL present DUMMY.
REQ-026 The slot counter SHALL advance on each transfer and wrap from NUM_CH+AUX_SLOTS-1 to 0; frames SHALL stream back-to-back with no idle cycle when cmd_ready is held high.
REQ-027 frame_count SHALL increment on each transfer of slot 0 and wrap from 16'hFFFF to 0.
REQ-028 stop_record in RECORD SHALL move the block to STOPPING. STOPPING completes the current frame and goes to IDLE on the transfer of the last slot. A stop on the same cycle as the last-slot transfer SHALL also end in IDLE with no new frame.
REQ-029 host_wr_ready SHALL equal not-full. A push and a pop in the same cycle SHALL both take effect when the FIFO is not full. Entries SHALL be issued in arrival order.
REQ-030 The aux-slot WRITE head entry SHALL be latched when the slot is first presented; pushes that follow SHALL NOT alter the presented command.

Reset
REQ-031 While rst is high, on the next edge: state = IDLE, FIFO empty, slot = 0, cmd_valid = 0, cmd_data = 0, cmd_slot = 0, cmd_frame_start = 0, busy = 0, frame_count = 0, host_wr_ready = 1.
REQ-032 rst asserted mid-command or mid-frame SHALL abandon the command with no further transfer and discard pending FIFO writes.

Verification
REQ-033 Calibration: start_calib, cmd_ready = 1 -> exactly 10 transfers (5500, then nine E800), busy falls after the tenth, frame_count = 0.
REQ-034 Streaming: NUM_CH = 64, AUX = 3, start_record, ready = 1 for 2 frames -> transfers 0000, 0100, ... 3F00, then E800 x3, repeated; frame_count = 2; cmd_frame_start is high only at slot 0.
REQ-035 Aux write: push (addr 5, data 0xAB) during frame 0 slot 10 -> slot 64 shows 85AB, slots 65 and 66 show E800, host_wr_ready stays 1.
REQ-036 Backpressure and FIFO full: cmd_ready toggles randomly, push 5 writes in IDLE with depth 4 -> host_wr_ready = 0 on the 5th until a pop. Commands stay stable while stalled. Four WRITEs issue in order, then the fifth.
REQ-037 Stop and races: stop_record at slot 30 -> last transfer is slot 66, then IDLE. start_calib and start_record in the same IDLE cycle -> CALIB only. start_record during CALIB -> ignored.
REQ-038 Reset mid-frame: rst at slot 20 with a 2-entry FIFO -> cmd_valid 0 the next cycle, host_wr_ready = 1, frame_count = 0; a new start_record begins at CONVERT(0).
